// File: rtl/up_timer_pkg.sv
// ---------------------------------------------------------------------------
// up_timer_pkg
// Shared definitions for the 16-bit programmable up-counting timer.
//   - timer_state_e : controller state (IDLE / RUN / DONE)
//   - MODE_*        : terminal-count behaviour selected by the mode input
//   - TIMER_WIDTH   : default counter / limit / load width
//   - inc_wrap()    : modulo-2^WIDTH increment used by the counter
// ---------------------------------------------------------------------------
package up_timer_pkg;

  localparam int unsigned TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } timer_state_e;

  // Behaviour when the count reaches the limit.
  localparam logic MODE_PERIODIC = 1'b0;  // wrap to zero, keep running
  localparam logic MODE_ONESHOT  = 1'b1;  // hold count, go to DONE

  // Increment with silent wrap-around at all-ones; no terminal count is
  // implied by this wrap, only a limit match produces tc.
  function automatic logic [TIMER_WIDTH-1:0] inc_wrap(
    input logic [TIMER_WIDTH-1:0] value
  );
    return value + TIMER_WIDTH'(1);
  endfunction

endpackage : up_timer_pkg

// File: rtl/up_timer16_sync_rst.sv
// ---------------------------------------------------------------------------
// up_timer16_sync_rst
// 16-bit start/stop-controlled up-counting timer with a programmable limit.
// At the limit it either wraps to zero (periodic) or holds and flags
// completion (one-shot). All outputs are registered.
//
// Ports
//   clock0      in   rising-edge clock
//   reset       in   synchronous active-low reset (0 = reset)
//   start       in   begin / resume counting (level, sampled each edge)
//   stop        in   halt counting, count held
//   load        in   load count from load_value, return to IDLE
//   load_value  in   WIDTH  value written to count on load
//   limit       in   WIDTH  terminal value, used live every cycle
//   mode        in   0 = periodic, 1 = one-shot
//   count       out  WIDTH  current count
//   running     out  high while in RUN
//   tc          out  one-cycle terminal-count pulse
//   done        out  sticky one-shot completion flag
//
// Edge priority: reset > load > stop > start > count.
// ---------------------------------------------------------------------------
module up_timer16_sync_rst
  import up_timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tc,
  output logic             done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q,    tc_d;
  logic             done_q,  done_d;

  logic             at_limit;

  // Live compare: limit/mode changes act at the very next compare.
  assign at_limit = (count_q == limit);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the if/case chain can leave one unassigned and infer a latch.
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;      // tc is a pulse: low unless a limit hit sets it
    done_d  = done_q;

    if (load) begin
      count_d = load_value;
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (stop) begin
      // stop outranks start in every state; it only has an effect in RUN.
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;   // resume from held or loaded value
          end
        end

        DONE: begin
          if (start) begin
            count_d = '0;
            done_d  = 1'b0;
            state_d = RUN;
          end
        end

        RUN: begin
          // start while running is ignored; just keep counting.
          if (at_limit) begin
            tc_d = 1'b1;
            if (mode == MODE_ONESHOT) begin
              done_d  = 1'b1;
              state_d = DONE;  // count held at limit
            end else begin
              count_d = '0;
            end
          end else begin
            count_d = WIDTH'(inc_wrap(TIMER_WIDTH'(count_q)));
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          state_d = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register with synchronous active-low reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clock0) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, matching real hardware.
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // -------------------------------------------------------------------------
  assign count   = count_q;
  assign running = (state_q == RUN);
  assign tc      = tc_q;
  assign done    = done_q;

endmodule : up_timer16_sync_rst

// File: tb/tb_up_timer16_sync_rst.sv
// ---------------------------------------------------------------------------
// tb_up_timer16_sync_rst
// Self-checking bench for up_timer16_sync_rst: a behavioural reference model
// checked every cycle, plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_up_timer16_sync_rst;

  logic        clock0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] limit;
  logic        mode;
  logic [15:0] count;
  logic        running;
  logic        tc;
  logic        done;

  up_timer16_sync_rst #(.WIDTH(16)) dut (
    .clock0     (clock0),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .mode       (mode),
    .count      (count),
    .running    (running),
    .tc         (tc),
    .done       (done)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // -------------------------------------------------------------------------
  // Reference model. The timer is described by three facts: the count value,
  // whether it is counting, and whether a one-shot has finished (finished is
  // exactly the sticky done flag).
  // -------------------------------------------------------------------------
  int m_count;
  bit m_counting;
  bit m_finished;
  bit m_tc;
  bit m_valid = 0;

  always @(posedge clock0) begin
    if (!reset) begin
      m_count    = 0;
      m_counting = 0;
      m_finished = 0;
      m_tc       = 0;
      m_valid    = 1;
    end else begin
      m_tc = 0;
      if (load) begin
        m_count    = int'(load_value);
        m_counting = 0;
        m_finished = 0;
      end else if (stop) begin
        m_counting = 0;
      end else if (start && !m_counting) begin
        if (m_finished) begin
          m_count    = 0;
          m_finished = 0;
        end
        m_counting = 1;
      end else if (m_counting) begin
        if (m_count == int'(limit)) begin
          m_tc = 1;
          if (mode) begin
            m_counting = 0;
            m_finished = 1;
          end else begin
            m_count = 0;
          end
        end else begin
          m_count = (m_count + 1) % 65536;
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clock0) begin
    if (m_valid) begin
      check("model_count",   32'(count),   32'(m_count));
      check("model_running", 32'(running), 32'(m_counting));
      check("model_tc",      32'(tc),      32'(m_tc));
      check("model_done",    32'(done),    32'(m_finished));
    end
  end

  task automatic tick();
    @(posedge clock0);
    @(negedge clock0);
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; load = 0;
  endtask

  int per_cnt[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int per_tc[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    reset = 0; start = 1; stop = 0; load = 0;
    load_value = 16'h0000; limit = 16'h0000; mode = 0;

    // Reset held for three edges with start asserted.
    repeat (3) tick();
    check("rst_count",   32'(count),   32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_tc",      32'(tc),      32'h0);
    check("rst_done",    32'(done),    32'h0);

    // Periodic, limit 3.
    reset = 1; limit = 16'd3; mode = 0; start = 1;
    tick();
    start = 0;
    check("per_start_count",   32'(count),   32'h0);
    check("per_start_running", 32'(running), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("per_count", 32'(count), 32'(per_cnt[i]));
      check("per_tc",    32'(tc),    32'(per_tc[i]));
    end
    stop = 1; tick(); stop = 0;
    check("per_stop_running", 32'(running), 32'h0);

    // One-shot, limit 5.
    load = 1; load_value = 16'd0; tick(); load = 0;
    limit = 16'd5; mode = 1; start = 1; tick(); start = 0;
    repeat (5) tick();
    check("os_pre_count", 32'(count), 32'd5);
    check("os_pre_tc",    32'(tc),    32'h0);
    tick();
    check("os_hit_count",   32'(count),   32'd5);
    check("os_hit_tc",      32'(tc),      32'h1);
    check("os_hit_done",    32'(done),    32'h1);
    check("os_hit_running", 32'(running), 32'h0);
    tick();
    check("os_hold_tc",    32'(tc),    32'h0);
    check("os_hold_done",  32'(done),  32'h1);
    check("os_hold_count", 32'(count), 32'd5);
    start = 1; tick(); start = 0;
    check("os_restart_count",   32'(count),   32'h0);
    check("os_restart_done",    32'(done),    32'h0);
    check("os_restart_running", 32'(running), 32'h1);
    stop = 1; tick(); stop = 0;

    // Wrap through 0xFFFF before reaching limit 1.
    load = 1; load_value = 16'hFFFE; tick(); load = 0;
    limit = 16'h0001; mode = 0; start = 1; tick(); start = 0;
    check("wrap_0", 32'(count), 32'hFFFE);
    tick(); check("wrap_1", 32'(count), 32'hFFFF);
    tick(); check("wrap_2", 32'(count), 32'h0000);
    check("wrap_no_tc", 32'(tc), 32'h0);
    tick(); check("wrap_3", 32'(count), 32'h0001);
    tick(); check("wrap_4", 32'(count), 32'h0000);
    check("wrap_tc", 32'(tc), 32'h1);
    stop = 1; tick(); stop = 0;

    // start + stop together in IDLE: stays IDLE.
    start = 1; stop = 1; tick(); idle_inputs();
    check("ss_idle_running", 32'(running), 32'h0);
    // load + stop in RUN: loaded value, IDLE.
    start = 1; tick(); start = 0;
    check("ls_pre_running", 32'(running), 32'h1);
    load = 1; stop = 1; load_value = 16'hABCD; tick(); idle_inputs();
    check("ls_count",   32'(count),   32'hABCD);
    check("ls_running", 32'(running), 32'h0);

    // limit 0 periodic: tc high every running cycle.
    load = 1; load_value = 16'h0; tick(); load = 0;
    limit = 16'h0; mode = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lim0_count", 32'(count), 32'h0);
      check("lim0_tc",    32'(tc),    32'h1);
    end
    stop = 1; tick(); stop = 0;

    // Reset while tc is due.
    load = 1; load_value = 16'h1233; tick(); load = 0;
    limit = 16'h1234; start = 1; tick(); start = 0;
    tick();
    check("rmid_pre_count", 32'(count), 32'h1234);
    reset = 0; tick(); reset = 1;
    check("rmid_count",   32'(count),   32'h0);
    check("rmid_running", 32'(running), 32'h0);
    check("rmid_tc",      32'(tc),      32'h0);

    // Mixed directed/pseudo-random traffic, checked by the model only.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 60) != 0);
      load  = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      start = ($urandom_range(0, 3) == 0);
      mode  = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) limit = 16'($urandom_range(0, 7));
      load_value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                : 16'($urandom_range(0, 9));
      tick();
    end
    idle_inputs();
    reset = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_up_timer16_sync_rst

// File: doc/up_timer16_sync_rst.md
# up_timer16_sync_rst

16-bit programmable up-counting timer, the counterpart of the team's free-running 16-bit down counter. It counts from a loaded or zero value up to a programmable limit. At the limit it either wraps (periodic) or stops (one-shot), and signals terminal count. It sits beside the down counter in the simple-registers counter set and serves as the event/period source for blocks that need a start/stop-controlled up count rather than a free-running decrement.

## Interface
- WIDTH, 16, counter, limit and load width
- clock0  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (sampled on clock0; 0 = reset)
- start  in  1  begin counting (level sampled each edge)
- stop  in  1  halt counting, hold count
- load  in  1  load count from load_value
- load_value  in  WIDTH  value written to count on load
- limit  in  WIDTH  terminal value, sampled live every cycle
- mode  in  1  0 = periodic (wrap to 0 at limit), 1 = one-shot (stop at limit)
- count  out  WIDTH  current count, registered
- running  out  1  high while in RUN
- tc  out  1  one-cycle terminal-count pulse, registered
- done  out  1  sticky one-shot completion flag

## Operation
- States: IDLE, RUN, DONE. running = (state == RUN).
- reset == 0 at an edge: state IDLE, count 0x0000, tc 0, done 0. Overrides all inputs.
- Priority, evaluated per edge: reset > load > stop > start > count.
- load: count <= load_value, state <= IDLE, done <= 0, tc <= 0. Allowed in any state.
- stop in RUN: state <= IDLE, count held, tc <= 0. In other states stop is a no-op.
- start in IDLE: state <= RUN, count unchanged (resumes from held/loaded value).
- start in DONE: count <= 0, done <= 0, state <= RUN.
- start in RUN: ignored. stop and start asserted together: stop wins.
- RUN, count != limit: count <= count + 1, modulo 2^WIDTH. 0xFFFF -> 0x0000 wraps silently with no tc. A loaded value above limit therefore reaches limit after wrapping.
- RUN, count == limit, mode 0: count <= 0, tc <= 1, stay RUN.
- RUN, count == limit, mode 1: count held, tc <= 1, done <= 1, state <= DONE.
- limit == 0, mode 0: count stays 0, tc high every cycle while running.
- tc is low in every cycle not directly following a limit hit.
- done clears only on reset, load, or start from DONE.
- limit and mode changes take effect at the next compare. No shadowing.

## Timing
- All outputs registered; no combinational input-to-output paths.
- start sampled at edge k: running = 1 after edge k, and the first increment occurs at edge k+1.
- Limit hit: count == limit before edge k, so tc = 1 for exactly the cycle after edge k. In periodic mode count = 0 in that cycle. In one-shot mode done = 1 and running = 0 in that cycle.
- Periodic period = limit + 1 cycles between tc pulses.
- Reset mid-count: count 0 and IDLE after the reset edge. A pending tc is dropped.

## Structure
- Shared package up_timer_pkg:
  - state typedef with encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10
  - MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1
- Single module with one clocked process for state, count, tc and done.
- The comparator and incrementer are inline; no sub-module is warranted.

## Test plan
- Reset: hold reset = 0 for 3 edges with start = 1 -> count 0x0000, running 0, tc 0, done 0.
- Periodic: limit 3, mode 0, start pulse.
  - count sequence 0,1,2,3,0,1…
  - tc high only in cycles where count = 0 after a wrap, every 4 cycles.
- One-shot: limit 5, mode 1, start.
  - Reaches 5, then tc pulses once, done = 1, running = 0, count holds 5.
  - A later start -> count 0, done 0, running 1.
- Wrap past limit: load 0xFFFE, limit 0x0001, mode 0, start.
  - count 0xFFFE, 0xFFFF, 0x0000, 0x0001, then 0x0000 with tc.
  - No tc at the 0xFFFF -> 0 wrap.
- Priority and edge cases:
  - start + stop in same cycle while IDLE -> stays IDLE.
  - load + stop in RUN -> count = load_value, IDLE.
  - limit 0, mode 0 -> tc continuously high.
- Reset mid-operation: reset = 0 at count 0x1234 in RUN with tc due -> next cycle count 0, IDLE, tc 0.
